// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the data-memory controller.
// Holds the FSM state encoding and the wait-counter sizing.
package dmem_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      RD_WAIT    = 2'd1,
      WR_WAIT    = 2'd2,
      WR_THEN_RD = 2'd3
   } state_t;

   localparam int MAX_LAT = 8;

   // The counter must be able to hold any load value MAX_LAT-1 with headroom.
   function automatic int cnt_width(input int max_lat);
      return $clog2(max_lat) + 1;
   endfunction

   localparam int CNT_W = cnt_width(MAX_LAT);

endpackage

// File: rtl/dmem_ctrl_if.sv
// LSU-facing read and write request interfaces.
// The LSU side is the Master; the memory controller is the Slave.
interface ReadIF;
   logic        avalid;
   logic [31:0] addr;
   logic [31:0] data;
   logic        valid;

   modport Master (output avalid, output addr, input data, input valid);
   modport Slave  (input avalid, input addr, output data, output valid);
endinterface

interface WriteIF;
   logic        valid;
   logic [31:0] addr;
   logic [31:0] data;
   logic [3:0]  strb;
   logic        done;

   modport Master (output valid, output addr, output data, output strb, input done);
   modport Slave  (input valid, input addr, input data, input strb, output done);
endinterface

// File: rtl/dmem_ram.sv
// Single-port word RAM with per-byte write enables and a registered read.
// The read register only updates on rd_en, so it holds the last word read.
module dmem_ram #(
   parameter int DEPTH_WORDS = 4096,
   localparam int AW = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          rd_en,
   input  logic [3:0]    we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
      if (rd_en) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: serialises one LSU read or write at a time onto
// a word RAM, with fixed per-access wait cycles and a sticky protocol error.
module dmem_ctrl
   import dmem_ctrl_pkg::*;
#(
   parameter int DEPTH_WORDS = 4096,
   parameter int RD_LAT      = 1,
   parameter int WR_LAT      = 1
) (
   input  logic   clk,
   input  logic   rst,
   ReadIF.Slave   r_bus,
   WriteIF.Slave  w_bus,
   output logic   proto_err
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT - 1);
   localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LAT - 1);

   if (DEPTH_WORDS < 4 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
      $error("dmem_ctrl: DEPTH_WORDS must be a power of two and at least 4");
   end
   if (RD_LAT < 1 || RD_LAT > MAX_LAT) begin : g_bad_rd_lat
      $error("dmem_ctrl: RD_LAT must be in 1..8");
   end
   if (WR_LAT < 1 || WR_LAT > MAX_LAT) begin : g_bad_wr_lat
      $error("dmem_ctrl: WR_LAT must be in 1..8");
   end

   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [AW-1:0]    pend_addr_reg;
   logic             valid_reg;
   logic             done_reg;
   logic [31:0]      hold_reg;
   logic             err_reg;

   logic          idle;
   logic          wr_acc;
   logic          rd_acc;
   logic          pend_rd;
   logic [AW-1:0] w_idx;
   logic [AW-1:0] r_idx;
   logic          ram_rd;
   logic [3:0]    ram_we;
   logic [AW-1:0] ram_addr;
   logic [31:0]   ram_rdata;
   logic          unused_addr_bits;

   assign idle  = (state_reg == IDLE);
   assign w_idx = w_bus.addr[2 +: AW];
   assign r_idx = r_bus.addr[2 +: AW];
   assign unused_addr_bits = ^{w_bus.addr[31:2+AW], w_bus.addr[1:0],
                               r_bus.addr[31:2+AW], r_bus.addr[1:0]};

   // Reset wins over acceptance, so no RAM access is launched on a reset edge.
   assign wr_acc  = !rst && idle && w_bus.valid;
   assign rd_acc  = !rst && idle && r_bus.avalid && !w_bus.valid;
   assign pend_rd = !rst && (state_reg == WR_THEN_RD) && (cnt_reg == '0);

   always_comb begin
      ram_we   = 4'b0000;
      ram_rd   = 1'b0;
      ram_addr = pend_addr_reg;
      if (wr_acc) begin
         ram_we   = w_bus.strb;
         ram_addr = w_idx;
      end else if (rd_acc) begin
         ram_rd   = 1'b1;
         ram_addr = r_idx;
      end else if (pend_rd) begin
         ram_rd   = 1'b1;
      end
   end

   dmem_ram #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_ram (
      .clk   (clk),
      .rd_en (ram_rd),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (w_bus.data),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         pend_addr_reg <= '0;
         valid_reg     <= 1'b0;
         done_reg      <= 1'b0;
         hold_reg      <= '0;
         err_reg       <= 1'b0;
      end else begin
         valid_reg <= 1'b0;
         done_reg  <= 1'b0;
         if (valid_reg) begin
            hold_reg <= ram_rdata;
         end
         if (!idle && (r_bus.avalid || w_bus.valid)) begin
            err_reg <= 1'b1;
         end
         case (state_reg)
            IDLE: begin
               if (w_bus.valid) begin
                  state_reg     <= r_bus.avalid ? WR_THEN_RD : WR_WAIT;
                  pend_addr_reg <= r_idx;
                  cnt_reg       <= WR_LOAD;
                  done_reg      <= (WR_LAT == 1);
               end else if (r_bus.avalid) begin
                  state_reg <= RD_WAIT;
                  cnt_reg   <= RD_LOAD;
                  valid_reg <= (RD_LAT == 1);
               end
            end
            RD_WAIT: begin
               if (cnt_reg == '0) begin
                  state_reg <= IDLE;
               end else begin
                  cnt_reg   <= cnt_reg - 1'b1;
                  valid_reg <= (cnt_reg == CNT_W'(1));
               end
            end
            WR_WAIT: begin
               if (cnt_reg == '0) begin
                  state_reg <= IDLE;
               end else begin
                  cnt_reg  <= cnt_reg - 1'b1;
                  done_reg <= (cnt_reg == CNT_W'(1));
               end
            end
            WR_THEN_RD: begin
               // The done cycle doubles as the launch of the pending read.
               if (cnt_reg == '0) begin
                  state_reg <= RD_WAIT;
                  cnt_reg   <= RD_LOAD;
                  valid_reg <= (RD_LAT == 1);
               end else begin
                  cnt_reg  <= cnt_reg - 1'b1;
                  done_reg <= (cnt_reg == CNT_W'(1));
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Between reads the data bus shows the held word; during valid it shows the fresh RAM word.
   assign r_bus.valid = valid_reg;
   assign r_bus.data  = valid_reg ? ram_rdata : hold_reg;
   assign w_bus.done  = done_reg;
   assign proto_err   = err_reg;

endmodule
